imem_loader: RTL and testbench

Boot-time program loader for the single-cycle RISC-V core. It is the write side of the instruction memory, which the core only reads. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses, and the core is held in reset until the programmed number of words has been stored.

---
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// Takes a valid/ready byte stream, assembles little-endian 32-bit words,
// writes them to consecutive word addresses, and holds the core in reset
// until the requested number of words has been stored.
module imem_loader #(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [31:0]       imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // FSM encoding
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_FINISH  = 2'd3;

   localparam logic [ADDR_W:0] CNT_ZERO = '0;
   localparam logic [ADDR_W:0] CNT_ONE  = 1;
   localparam logic [31:0]     WORD_STEP = 32'd4;

   // Control state
   logic [1:0]      state_reg,     state_next;
   logic [ADDR_W:0] count_reg,     count_next;
   logic [ADDR_W:0] word_cnt_reg,  word_cnt_next;
   logic [ADDR_W:0] word_cnt_inc;
   logic [1:0]      byte_idx_reg,  byte_idx_next;
   logic [31:0]     addr_reg,      addr_next;

   // Registered outputs
   logic            ready_reg,     ready_next;
   logic            we_reg,        we_next;
   logic            cpu_reset_reg, cpu_reset_next;
   logic            busy_reg,      busy_next;
   logic            done_reg,      done_next;
   logic            err_reg,       err_next;

   // Byte-lane write strobes and the assembled word
   logic [3:0]      lane_we;
   logic [31:0]     word_data;
   logic            accept;

   // A byte is consumed only when we advertised readiness in the previous edge
   assign accept       = byte_valid && ready_reg;
   assign word_cnt_inc = word_cnt_reg + CNT_ONE;

   // Next-state and next-output decode
   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      word_cnt_next  = word_cnt_reg;
      byte_idx_next  = byte_idx_reg;
      addr_next      = addr_reg;
      ready_next     = ready_reg;
      we_next        = 1'b0;
      cpu_reset_next = cpu_reset_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      err_next       = err_reg;
      lane_we        = 4'b0000;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               if (word_count != CNT_ZERO) begin
                  count_next     = word_count;
                  word_cnt_next  = CNT_ZERO;
                  byte_idx_next  = 2'd0;
                  addr_next      = BASE_ADDR;
                  err_next       = 1'b0;
                  busy_next      = 1'b1;
                  cpu_reset_next = 1'b1;
                  ready_next     = 1'b1;
                  state_next     = S_COLLECT;
               end else begin
                  // Empty load request: flag it, leave the core's reset alone
                  err_next = 1'b1;
               end
            end
         end

         S_COLLECT: begin
            if (accept) begin
               lane_we       = 4'b0001 << byte_idx_reg;
               byte_idx_next = byte_idx_reg + 2'd1;
               if (byte_idx_reg == 2'd3) begin
                  // Word complete: stop accepting and issue the write
                  ready_next = 1'b0;
                  we_next    = 1'b1;
                  state_next = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            // The write happens this cycle; advance bookkeeping for the next word
            word_cnt_next = word_cnt_inc;
            addr_next     = addr_reg + WORD_STEP;
            byte_idx_next = 2'd0;
            if (word_cnt_inc == count_reg) begin
               done_next      = 1'b1;
               busy_next      = 1'b0;
               cpu_reset_next = 1'b0;
               state_next     = S_FINISH;
            end else begin
               ready_next = 1'b1;
               state_next = S_COLLECT;
            end
         end

         S_FINISH: begin
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // FSM and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         count_reg    <= CNT_ZERO;
         word_cnt_reg <= CNT_ZERO;
         byte_idx_reg <= 2'd0;
         addr_reg     <= BASE_ADDR;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         word_cnt_reg <= word_cnt_next;
         byte_idx_reg <= byte_idx_next;
         addr_reg     <= addr_next;
      end
   end

   // Registered status and handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_reg     <= 1'b0;
         we_reg        <= 1'b0;
         cpu_reset_reg <= 1'b1;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         ready_reg     <= ready_next;
         we_reg        <= we_next;
         cpu_reset_reg <= cpu_reset_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

   // One byte register per lane; a reset discards any partial word
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_reg;

         // Capture the incoming byte into this lane on its handshake
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               lane_reg <= 8'h00;
            end else if (lane_we[gi]) begin
               lane_reg <= byte_data;
            end
         end

         assign word_data[8*gi +: 8] = lane_reg;
      end
   endgenerate

   assign byte_ready = ready_reg;
   assign imem_we    = we_reg;
   assign imem_waddr = addr_reg;
   assign imem_wdata = word_data;
   assign cpu_reset  = cpu_reset_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a table of per-cycle vectors for the basic
// load and zero-count behaviour, plus hand-written sequences for gaps,
// mid-load start/reset and a full-depth load.
module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W:0]   word_count;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [31:0]       imem_waddr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              err;

   int nvec = 0;
   int nerr = 0;

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write and done monitor
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   logic        log_rdy  [$];
   int          done_cnt = 0;

   always @(negedge clk) begin
      if (imem_we) begin
         log_addr.push_back(imem_waddr);
         log_data.push_back(imem_wdata);
         log_rdy.push_back(byte_ready);
      end
      if (done) done_cnt++;
   end

   typedef struct {
      logic        start;
      logic [8:0]  wc;
      logic        valid;
      logic [7:0]  data;
      logic        ready;
      logic        we;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic        cpu;
      logic        busy;
      logic        done;
      logic        err;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(logic s, logic [8:0] w, logic v, logic [7:0] d,
                               logic rdy, logic we, logic [31:0] a, logic [31:0] wd,
                               logic c, logic b, logic dn, logic e);
      vec_t r;
      r.start = s;  r.wc = w;   r.valid = v; r.data = d;
      r.ready = rdy; r.we = we; r.waddr = a; r.wdata = wd;
      r.cpu = c; r.busy = b; r.done = dn; r.err = e;
      return r;
   endfunction

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] outs();
      return {byte_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte after 'gap' idle cycles and wait for its handshake
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         tick();
      end
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         nvec++;
         nerr++;
         $display("FAIL send_byte_timeout actual=ready_low required=ready_high");
      end
      tick();
      // Keep valid high with a junk byte; it must not be consumed while ready=0
      byte_data = 8'hEE;
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      while (!done && n < bound) begin
         tick();
         n++;
      end
      nvec++;
      if (!done) begin
         nerr++;
         $display("FAIL wait_done actual=timeout required=done_pulse");
      end
   endtask

   task automatic start_load(input logic [8:0] wc);
      byte_valid = 1'b0;
      start      = 1'b1;
      word_count = wc;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int l0, d0;
      logic [7:0] pb;
      logic [31:0] exp_w;

      reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = 8'h00;

      // ---- Reset values (checked while reset is held) ----
      tick();
      tick();
      chk("reset_state", outs(), {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      reset = 1'b0;

      // ---- Table: zero count, then two-word load at full rate ----
      //             start wc     vld data   rdy  we   waddr  wdata          cpu busy done err
      tbl[0]  = mk(1, 9'd0, 0, 8'h00,  0, 0, 32'h0, 32'h00000000, 1, 0, 0, 1);
      tbl[1]  = mk(0, 9'd0, 0, 8'h00,  0, 0, 32'h0, 32'h00000000, 1, 0, 0, 1);
      tbl[2]  = mk(1, 9'd2, 0, 8'h00,  1, 0, 32'h0, 32'h00000000, 1, 1, 0, 0);
      tbl[3]  = mk(0, 9'd0, 1, 8'h13,  1, 0, 32'h0, 32'h00000013, 1, 1, 0, 0);
      tbl[4]  = mk(0, 9'd0, 1, 8'h05,  1, 0, 32'h0, 32'h00000513, 1, 1, 0, 0);
      tbl[5]  = mk(0, 9'd0, 1, 8'h50,  1, 0, 32'h0, 32'h00500513, 1, 1, 0, 0);
      tbl[6]  = mk(0, 9'd0, 1, 8'h00,  0, 1, 32'h0, 32'h00500513, 1, 1, 0, 0);
      tbl[7]  = mk(0, 9'd0, 1, 8'h93,  1, 0, 32'h4, 32'h00500513, 1, 1, 0, 0);
      tbl[8]  = mk(0, 9'd0, 1, 8'h93,  1, 0, 32'h4, 32'h00500593, 1, 1, 0, 0);
      tbl[9]  = mk(0, 9'd0, 1, 8'h05,  1, 0, 32'h4, 32'h00500593, 1, 1, 0, 0);
      tbl[10] = mk(0, 9'd0, 1, 8'hA0,  1, 0, 32'h4, 32'h00A00593, 1, 1, 0, 0);
      tbl[11] = mk(0, 9'd0, 1, 8'h00,  0, 1, 32'h4, 32'h00A00593, 1, 1, 0, 0);
      tbl[12] = mk(0, 9'd0, 0, 8'h00,  0, 0, 32'h8, 32'h00A00593, 0, 0, 1, 0);
      tbl[13] = mk(0, 9'd0, 0, 8'h00,  0, 0, 32'h8, 32'h00A00593, 0, 0, 0, 0);
      tbl[14] = mk(1, 9'd0, 0, 8'h00,  0, 0, 32'h8, 32'h00A00593, 0, 0, 0, 1);

      for (int i = 0; i < 15; i++) begin
         start      = tbl[i].start;
         word_count = tbl[i].wc;
         byte_valid = tbl[i].valid;
         byte_data  = tbl[i].data;
         tick();
         chk($sformatf("tbl[%0d]", i), outs(),
             {tbl[i].ready, tbl[i].we, tbl[i].waddr, tbl[i].wdata,
              tbl[i].cpu, tbl[i].busy, tbl[i].done, tbl[i].err});
         $display("vec %0d: we=%b waddr=%h wdata=%h cpu_reset=%b done=%b err=%b",
                  i, imem_we, imem_waddr, imem_wdata, cpu_reset, done, err);
      end
      start = 1'b0; byte_valid = 1'b0;

      // ---- Backpressure and gaps ----
      begin
         logic [7:0] stream [8];
         stream[0] = 8'h13; stream[1] = 8'h05; stream[2] = 8'h50; stream[3] = 8'h00;
         stream[4] = 8'h93; stream[5] = 8'h05; stream[6] = 8'hA0; stream[7] = 8'h00;
         l0 = log_addr.size(); d0 = done_cnt;
         start_load(9'd2);
         chk("err_cleared_by_start", {71'd0, err}, 72'd0);
         for (int i = 0; i < 8; i++)
            send_byte(stream[i], (i == 4) ? 0 : int'($urandom_range(0, 3)));
         wait_done(40);
         byte_valid = 1'b0;
         chk("bp_cpu_reset_at_done", {70'd0, cpu_reset, busy}, 72'd0);
         tick(); tick(); tick();
         chk("bp_write_count", 72'(log_addr.size() - l0), 72'd2);
         if (log_addr.size() - l0 == 2) begin
            chk("bp_w0", {8'd0, log_addr[l0],   log_data[l0]},   {8'd0, 32'h0, 32'h00500513});
            chk("bp_w1", {8'd0, log_addr[l0+1], log_data[l0+1]}, {8'd0, 32'h4, 32'h00A00593});
            chk("bp_ready_low_in_write", {70'd0, log_rdy[l0], log_rdy[l0+1]}, 72'd0);
         end
         chk("bp_done_count", 72'(done_cnt - d0), 72'd1);
         $display("backpressure load: %0d writes", log_addr.size() - l0);
      end

      // ---- start ignored in COLLECT, reset after 6 bytes of a 3-word load ----
      l0 = log_addr.size();
      start_load(9'd3);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      byte_valid = 1'b0;
      start = 1'b1; word_count = 9'd1;
      tick();
      start = 1'b0;
      chk("start_ignored_in_collect", {70'd0, busy, byte_ready}, 72'd3);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      reset = 1'b1;
      #1;
      chk("midload_reset_state", outs(), {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      byte_valid = 1'b0;
      tick();
      chk("midload_write_count", 72'(log_addr.size() - l0), 72'd1);
      if (log_addr.size() - l0 == 1)
         chk("midload_w0", {8'd0, log_addr[l0], log_data[l0]}, {8'd0, 32'h0, 32'h44332211});
      $display("mid-load reset: %0d writes kept", log_addr.size() - l0);

      // Release reset and raise start together; start takes effect on the next edge
      l0 = log_addr.size(); d0 = done_cnt;
      reset = 1'b0; start = 1'b1; word_count = 9'd1;
      tick();
      start = 1'b0;
      chk("restart_after_reset", {70'd0, busy, byte_ready}, 72'd3);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      wait_done(10);
      byte_valid = 1'b0;
      tick();
      chk("restart_write_count", 72'(log_addr.size() - l0), 72'd1);
      if (log_addr.size() - l0 == 1)
         chk("restart_w0", {8'd0, log_addr[l0], log_data[l0]}, {8'd0, 32'h0, 32'hDDCCBBAA});
      $display("restart load: %0d writes", log_addr.size() - l0);

      // ---- Full depth ----
      l0 = log_addr.size(); d0 = done_cnt;
      start_load(9'd256);
      chk("full_cpu_reset_raised", {70'd0, cpu_reset, busy}, 72'd3);
      for (int i = 0; i < 1024; i++) begin
         pb = i[7:0];
         send_byte(pb, 0);
      end
      wait_done(20);
      byte_valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("full_write_count", 72'(log_addr.size() - l0), 72'd256);
      if (log_addr.size() - l0 == 256) begin
         for (int k = 0; k < 256; k++) begin
            exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            chk($sformatf("full_w%0d", k), {8'd0, log_addr[l0+k], log_data[l0+k]},
                {8'd0, 32'(4*k), exp_w});
         end
         chk("full_last_addr", {40'd0, log_addr[l0+255]}, {40'd0, 32'h000003FC});
      end
      chk("full_done_count", 72'(done_cnt - d0), 72'd1);
      chk("full_end_state", {70'd0, cpu_reset, busy}, 72'd0);
      $display("full-depth load: %0d writes", log_addr.size() - l0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
